hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard/forwarding unit for the 5-stage pipelined core, the successor to the present combinational hazard unit. It adds a multi-cycle multiply/divide scoreboard with configurable latency, a generalised destination-based load-use check and a saturating stall-cycle performance counter. It sits inside the core controller and drives the same stall, flush and forwarding controls into the datapath.

## Interface
Parameters:
- REG_W, 5, register-address width.
- MD_LATENCY, 4, cycles a multi-cycle op occupies the MD unit; legal range 2..255.
- CNT_W, 32, stall-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rs_d, rt_d  in  REG_W  source registers of the instruction in D.
- rs_x, rt_x  in  REG_W  source registers of the instruction in X.
- write_reg_x, write_reg_m, write_reg_w  in  REG_W  destination registers in X/M/W.
- reg_write_x, reg_write_m, reg_write_w  in  1  register-write enables in X/M/W.
- mem_to_reg_x, mem_to_reg_m  in  1  load in X/M.
- branch_d  in  1  branch in D.
- md_start_d  in  1  D holds a multi-cycle MD op.
- md_dest_d  in  REG_W  destination of that MD op.
- stall_clear  in  1  synchronous clear of stall_count.
- stall_f, stall_d, flush_x  out  1  pipeline hold/bubble controls.
- fwd_a_d, fwd_b_d  out  1  forward ALU result in M to the D-stage comparator.
- fwd_a_x, fwd_b_x  out  2  X-operand select: 00 regfile, 01 W, 10 M.
- md_busy  out  1  MD unit occupied.
- md_done  out  1  one-cycle pulse; MD result is written this cycle.
- md_dest  out  REG_W  latched MD destination.
- stall_count  out  CNT_W  saturating count of stalled cycles.

## Operation
- Register 0 never matches in any comparison below.
- X forwarding, per operand: 10 if the operand equals write_reg_m and reg_write_m; else 01 if it equals write_reg_w and reg_write_w; else 00. M takes priority over W.
- D forwarding: fwd_a_d = rs_d==write_reg_m & reg_write_m; fwd_b_d likewise for rt_d.
- lw_stall = mem_to_reg_x & (write_reg_x == rs_d or rt_d).
- br_stall = branch_d & ((reg_write_x & write_reg_x == rs_d or rt_d) or (mem_to_reg_m & write_reg_m == rs_d or rt_d)).
- md_stall = md_busy & (rs_d==md_dest or rt_d==md_dest or md_start_d). The last term is a structural stall: only one MD op may be in flight.
- stall = lw_stall | br_stall | md_stall. stall_f = stall_d = flush_x = stall.
- MD FSM, states IDLE and BUSY:
  - IDLE -> BUSY when md_start_d & !stall. On that edge, latch md_dest = md_dest_d and load cnt = MD_LATENCY-1.
  - BUSY: cnt decrements each cycle. md_done = BUSY & cnt==0. BUSY -> IDLE on the edge after md_done.
  - md_busy = (state == BUSY).
- stall_count: on each edge where stall=1, increment and hold at all-ones. stall_clear has priority over increment. Clearing while stalled yields 0, not 1.

## Timing
- Reset (reset_n=0 at an edge): state IDLE, cnt 0, md_dest 0, stall_count 0. Combinational outputs then follow inputs with md_busy=0, md_done=0. A reset during BUSY abandons the op and produces no md_done.
- All stall and forwarding outputs are combinational from current inputs and state; there is no added latency.
- MD op accepted at edge t: md_busy=1 in cycles t+1 .. t+MD_LATENCY, md_done=1 only in cycle t+MD_LATENCY, md_busy=0 from t+MD_LATENCY+1.
- A dependent or second MD instruction in D stalls through the md_done cycle and proceeds in the following cycle. A second MD op is accepted at the edge ending cycle t+MD_LATENCY+1.
- If md_start_d coincides with lw_stall or br_stall, the op is not accepted; acceptance re-evaluates each cycle.
- stall_count is visible one cycle after the stalled cycle.

## Test plan
- Forwarding: write_reg_m=write_reg_w=5, both write enables =1, rs_x=5 -> fwd_a_x=10. Then reg_write_m=0 -> 01. Then rs_x=0 -> 00.
- Load-use: mem_to_reg_x=1, write_reg_x=8, rt_d=8 -> stall_f=stall_d=flush_x=1 for exactly one cycle. stall_count goes 0->1.
- Branch: branch_d=1, reg_write_x=1, write_reg_x=3, rs_d=3 -> stall. Next cycle, same register now in M with mem_to_reg_m=0 -> no stall, fwd_a_d=1.
- MD, MD_LATENCY=4: accept an MD op to r9, then hold rs_d=9 in D -> md_busy for 4 cycles, md_done only in the 4th, stall in all 4, release in the 5th. A back-to-back md_start_d is accepted at the edge ending the 5th cycle.
- Reset mid-BUSY: reset_n=0 for one edge at cnt=2 -> md_busy=0, no md_done, stall_count=0.
- Counter: force stall for 2^CNT_W+3 cycles (CNT_W=4) -> stall_count saturates at 15. stall_clear asserted together with stall -> stall_count=0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Hazard-unit connection bundle between the core controller (master) and
// the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] rs_d, rt_d, rs_x, rt_x;
  logic [REG_W-1:0] write_reg_x, write_reg_m, write_reg_w;
  logic             reg_write_x, reg_write_m, reg_write_w;
  logic             mem_to_reg_x, mem_to_reg_m;
  logic             branch_d;
  logic             md_start_d;
  logic [REG_W-1:0] md_dest_d;
  logic             stall_clear;

  logic             stall_f, stall_d, flush_x;
  logic             fwd_a_d, fwd_b_d;
  logic [1:0]       fwd_a_x, fwd_b_x;
  logic             md_busy, md_done;
  logic [REG_W-1:0] md_dest;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output rs_d, rt_d, rs_x, rt_x, write_reg_x, write_reg_m, write_reg_w,
           reg_write_x, reg_write_m, reg_write_w, mem_to_reg_x, mem_to_reg_m,
           branch_d, md_start_d, md_dest_d, stall_clear,
    input  stall_f, stall_d, flush_x, fwd_a_d, fwd_b_d, fwd_a_x, fwd_b_x,
           md_busy, md_done, md_dest, stall_count
  );

  modport slave (
    input  rs_d, rt_d, rs_x, rt_x, write_reg_x, write_reg_m, write_reg_w,
           reg_write_x, reg_write_m, reg_write_w, mem_to_reg_x, mem_to_reg_m,
           branch_d, md_start_d, md_dest_d, stall_clear,
    output stall_f, stall_d, flush_x, fwd_a_d, fwd_b_d, fwd_a_x, fwd_b_x,
           md_busy, md_done, md_dest, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit with a single-slot multi-cycle MD scoreboard and a
// saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int REG_W      = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input logic                clk,
  input logic                reset_n,
  hazard_scoreboard_if.slave bus
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  md_state_e        state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [REG_W-1:0] dest_q, dest_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lw_stall, br_stall, md_stall, stall;
  logic busy;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_hit(logic [REG_W-1:0] a, logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(logic [REG_W-1:0] src);
    if (bus.reg_write_m && reg_hit(src, bus.write_reg_m))      return 2'b10;
    else if (bus.reg_write_w && reg_hit(src, bus.write_reg_w)) return 2'b01;
    else                                                       return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dest_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dest_q      <= dest_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    case (state_q)
      IDLE: begin
        if (bus.md_start_d && !stall) begin
          state_d = BUSY;
          cnt_d   = 8'(MD_LATENCY - 1);
          dest_d  = bus.md_dest_d;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear wins over increment, so clearing during a stall lands on zero.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.stall_clear) stall_cnt_d = '0;
    else if (stall)      stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_comb begin
    busy     = (state_q == BUSY);
    lw_stall = bus.mem_to_reg_x &&
               (reg_hit(bus.rs_d, bus.write_reg_x) || reg_hit(bus.rt_d, bus.write_reg_x));
    br_stall = bus.branch_d &&
               ((bus.reg_write_x &&
                 (reg_hit(bus.rs_d, bus.write_reg_x) || reg_hit(bus.rt_d, bus.write_reg_x))) ||
                (bus.mem_to_reg_m &&
                 (reg_hit(bus.rs_d, bus.write_reg_m) || reg_hit(bus.rt_d, bus.write_reg_m))));
    // md_start_d while busy is a structural hazard: one MD op in flight.
    md_stall = busy &&
               (reg_hit(bus.rs_d, dest_q) || reg_hit(bus.rt_d, dest_q) || bus.md_start_d);
    stall    = lw_stall || br_stall || md_stall;

    bus.stall_f     = stall;
    bus.stall_d     = stall;
    bus.flush_x     = stall;
    bus.fwd_a_d     = bus.reg_write_m && reg_hit(bus.rs_d, bus.write_reg_m);
    bus.fwd_b_d     = bus.reg_write_m && reg_hit(bus.rt_d, bus.write_reg_m);
    bus.fwd_a_x     = fwd_sel(bus.rs_x);
    bus.fwd_b_x     = fwd_sel(bus.rt_x);
    bus.md_busy     = busy;
    bus.md_done     = busy && (cnt_q == '0);
    bus.md_dest     = dest_q;
    bus.stall_count = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: combinational vector table plus
// multi-cycle sequences for the MD scoreboard, reset and counter saturation.
module tb_hazard_scoreboard;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int LAT   = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard #(.REG_W(REG_W), .MD_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_x, rt_x, wx, wm, ww;
    logic       rwx, rwm, rww, mtrx, mtrm, br;
    logic       e_stall, e_fad, e_fbd;
    logic [1:0] e_fax, e_fbx;
  } vec_t;

  vec_t vecs[15];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    bus.rs_d = '0; bus.rt_d = '0; bus.rs_x = '0; bus.rt_x = '0;
    bus.write_reg_x = '0; bus.write_reg_m = '0; bus.write_reg_w = '0;
    bus.reg_write_x = 0; bus.reg_write_m = 0; bus.reg_write_w = 0;
    bus.mem_to_reg_x = 0; bus.mem_to_reg_m = 0; bus.branch_d = 0;
    bus.md_start_d = 0; bus.md_dest_d = '0; bus.stall_clear = 0;
  endtask

  task automatic chk_stall(input string name, input int exp);
    chk({name, ".stall_f"}, int'(bus.stall_f), exp);
    chk({name, ".stall_d"}, int'(bus.stall_d), exp);
    chk({name, ".flush_x"}, int'(bus.flush_x), exp);
  endtask

  task automatic clear_count();
    bus.stall_clear = 1;
    @(negedge clk);
    bus.stall_clear = 0;
  endtask

  initial begin
    //          rs_d rt_d rs_x rt_x wx wm ww  rwx rwm rww mtrx mtrm br  stall fad fbd fax fbx
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 2'd0, 2'd0};
    vecs[1]  = '{0, 0, 5, 0, 0, 5, 5,  0, 1, 1, 0, 0, 0,  0, 0, 0, 2'd2, 2'd0};
    vecs[2]  = '{0, 0, 5, 0, 0, 5, 5,  0, 0, 1, 0, 0, 0,  0, 0, 0, 2'd1, 2'd0};
    vecs[3]  = '{0, 0, 0, 0, 0, 5, 5,  0, 1, 1, 0, 0, 0,  0, 0, 0, 2'd0, 2'd0};
    vecs[4]  = '{0, 0, 5, 6, 0, 5, 6,  0, 1, 1, 0, 0, 0,  0, 0, 0, 2'd2, 2'd1};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1, 1, 1,  0, 0, 0, 2'd0, 2'd0};
    vecs[6]  = '{0, 8, 0, 0, 8, 0, 0,  0, 0, 0, 1, 0, 0,  1, 0, 0, 2'd0, 2'd0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0,  0, 0, 0, 2'd0, 2'd0};
    vecs[8]  = '{3, 0, 0, 0, 3, 0, 0,  1, 0, 0, 0, 0, 1,  1, 0, 0, 2'd0, 2'd0};
    vecs[9]  = '{3, 0, 0, 0, 0, 3, 0,  0, 1, 0, 0, 0, 1,  0, 1, 0, 2'd0, 2'd0};
    vecs[10] = '{3, 0, 0, 0, 0, 3, 0,  0, 1, 0, 0, 1, 1,  1, 1, 0, 2'd0, 2'd0};
    vecs[11] = '{3, 0, 0, 0, 3, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0, 0, 2'd0, 2'd0};
    vecs[12] = '{0, 7, 0, 0, 0, 7, 0,  0, 1, 0, 0, 0, 0,  0, 0, 1, 2'd0, 2'd0};
    vecs[13] = '{8, 0, 0, 0, 8, 0, 0,  0, 0, 0, 1, 0, 0,  1, 0, 0, 2'd0, 2'd0};
    vecs[14] = '{0, 0, 4, 4, 0, 4, 4,  0, 0, 1, 0, 0, 0,  0, 0, 0, 2'd1, 2'd1};

    clr_in();
    reset_n = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.md_busy", int'(bus.md_busy), 0);
    chk("rst.md_done", int'(bus.md_done), 0);
    chk("rst.md_dest", int'(bus.md_dest), 0);
    chk("rst.stall_count", int'(bus.stall_count), 0);
    reset_n = 1;
    @(negedge clk);

    // Combinational table; each vector occupies one cycle.
    for (int i = 0; i < 15; i++) begin
      bus.rs_d = vecs[i].rs_d; bus.rt_d = vecs[i].rt_d;
      bus.rs_x = vecs[i].rs_x; bus.rt_x = vecs[i].rt_x;
      bus.write_reg_x = vecs[i].wx; bus.write_reg_m = vecs[i].wm; bus.write_reg_w = vecs[i].ww;
      bus.reg_write_x = vecs[i].rwx; bus.reg_write_m = vecs[i].rwm; bus.reg_write_w = vecs[i].rww;
      bus.mem_to_reg_x = vecs[i].mtrx; bus.mem_to_reg_m = vecs[i].mtrm; bus.branch_d = vecs[i].br;
      #1;
      chk_stall($sformatf("vec%0d", i), int'(vecs[i].e_stall));
      chk($sformatf("vec%0d.fwd_a_d", i), int'(bus.fwd_a_d), int'(vecs[i].e_fad));
      chk($sformatf("vec%0d.fwd_b_d", i), int'(bus.fwd_b_d), int'(vecs[i].e_fbd));
      chk($sformatf("vec%0d.fwd_a_x", i), int'(bus.fwd_a_x), int'(vecs[i].e_fax));
      chk($sformatf("vec%0d.fwd_b_x", i), int'(bus.fwd_b_x), int'(vecs[i].e_fbx));
      @(negedge clk);
    end
    clr_in();
    #1;
    chk("table.stall_count", int'(bus.stall_count), 4);
    clear_count();
    #1;
    chk("clear.stall_count", int'(bus.stall_count), 0);

    // Load-use for exactly one cycle.
    bus.mem_to_reg_x = 1; bus.write_reg_x = 8; bus.rt_d = 8;
    #1 chk_stall("lw", 1);
    @(negedge clk);
    clr_in();
    #1;
    chk_stall("lw.after", 0);
    chk("lw.stall_count", int'(bus.stall_count), 1);
    clear_count();

    // MD start blocked by a load-use stall, then accepted.
    bus.md_start_d = 1; bus.md_dest_d = 9;
    bus.mem_to_reg_x = 1; bus.write_reg_x = 8; bus.rt_d = 8;
    #1 chk_stall("md.blocked", 1);
    @(negedge clk);
    bus.mem_to_reg_x = 0; bus.rt_d = 0;
    #1;
    chk("md.not_accepted", int'(bus.md_busy), 0);
    chk_stall("md.accept", 0);
    @(negedge clk);
    clr_in();
    bus.stall_clear = 1;
    // Dependent reader plus a second MD op held in D.
    bus.rs_d = 9; bus.md_start_d = 1; bus.md_dest_d = 10;
    for (int k = 1; k <= LAT; k++) begin
      #1;
      chk($sformatf("md.c%0d.busy", k), int'(bus.md_busy), 1);
      chk($sformatf("md.c%0d.done", k), int'(bus.md_done), (k == LAT) ? 1 : 0);
      chk($sformatf("md.c%0d.dest", k), int'(bus.md_dest), 9);
      chk_stall($sformatf("md.c%0d", k), 1);
      @(negedge clk);
      bus.stall_clear = 0;
    end
    #1;
    chk("md.c5.busy", int'(bus.md_busy), 0);
    chk("md.c5.done", int'(bus.md_done), 0);
    chk_stall("md.c5", 0);
    chk("md.stall_count", int'(bus.stall_count), 3);
    @(negedge clk);
    bus.md_start_d = 0; bus.rs_d = 0;
    #1;
    chk("md2.busy", int'(bus.md_busy), 1);
    chk("md2.dest", int'(bus.md_dest), 10);
    chk("md2.done", int'(bus.md_done), 0);
    @(negedge clk);

    // Reset while the second op has cnt=2.
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    #1;
    chk("rstbusy.md_busy", int'(bus.md_busy), 0);
    chk("rstbusy.md_done", int'(bus.md_done), 0);
    chk("rstbusy.stall_count", int'(bus.stall_count), 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1 chk($sformatf("rstbusy.nodone%0d", k), int'(bus.md_done | bus.md_busy), 0);
    end

    // Saturation: 2^CNT_W+3 stalled cycles.
    @(negedge clk);
    bus.mem_to_reg_x = 1; bus.write_reg_x = 8; bus.rs_d = 8;
    for (int k = 1; k <= (1 << CNT_W) + 3; k++) begin
      @(negedge clk);
      if (k == 15 || k == 16) #1 chk($sformatf("sat.k%0d", k), int'(bus.stall_count), 15);
    end
    #1 chk("sat.final", int'(bus.stall_count), 15);
    bus.stall_clear = 1;
    @(negedge clk);
    bus.stall_clear = 0;
    #1;
    chk_stall("sat.clear", 1);
    chk("sat.clear_while_stall", int'(bus.stall_count), 0);
    @(negedge clk);
    clr_in();
    #1 chk("sat.reincrement", int'(bus.stall_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
